// File: rtl/uart_line_rx.sv
// Line assembler between the UART receive stream and the command FSM.
// It handles backspace editing and overflow, can echo to the UART transmitter, and presents one line per CR.
module uart_line_rx #(
    parameter int LINE_LEN = 32,
    parameter int ECHO     = 1
) (
    input  logic                  clk_48mhz,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            echo_data,
    output logic                  echo_valid,
    input  logic                  echo_ready,
    output logic [8*LINE_LEN-1:0] line_text,
    output logic [7:0]            line_length,
    output logic                  line_overflow,
    output logic                  line_valid,
    input  logic                  line_ready
);

    localparam logic [7:0] LEN_MAX = 8'(LINE_LEN);
    localparam bit         ECHO_EN = (ECHO != 0);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  count_reg, count_next;
    logic        overflow_reg, overflow_next;
    logic [7:0]  echo_q_reg [3];
    logic [7:0]  echo_q_next [3];
    logic [1:0]  echo_occ_reg, echo_occ_next;

    logic [7:0]  load_b [3];
    logic [1:0]  load_n;
    logic        text_we;
    logic        text_clr;
    logic [7:0]  text_idx;
    logic [7:0]  text_val;

    logic        echo_empty;
    logic        accept;
    logic        line_take;
    logic        is_print;
    logic        is_bs;
    logic        is_cr;

    assign echo_empty    = (echo_occ_reg == 2'd0);
    assign in_ready      = (state_reg == COLLECT) && echo_empty;
    assign line_valid    = (state_reg == HOLD) && echo_empty;
    assign accept        = in_valid && in_ready;
    assign line_take     = line_valid && line_ready;
    assign echo_valid    = !echo_empty;
    assign echo_data     = echo_q_reg[0];
    assign line_length   = count_reg;
    assign line_overflow = overflow_reg;

    assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign is_bs    = (in_data == 8'h08) || (in_data == 8'h7F);
    assign is_cr    = (in_data == 8'h0D);

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        echo_q_next   = echo_q_reg;
        echo_occ_next = echo_occ_reg;
        load_b[0]     = 8'h00;
        load_b[1]     = 8'h00;
        load_b[2]     = 8'h00;
        load_n        = 2'd0;
        text_we       = 1'b0;
        text_clr      = 1'b0;
        text_idx      = count_reg;
        text_val      = 8'h00;

        if (!echo_empty && echo_ready) begin
            echo_q_next[0] = echo_q_reg[1];
            echo_q_next[1] = echo_q_reg[2];
            echo_q_next[2] = 8'h00;
            echo_occ_next  = echo_occ_reg - 2'd1;
        end

        if (accept) begin
            if (is_print) begin
                if (count_reg < LEN_MAX) begin
                    text_we    = 1'b1;
                    text_idx   = count_reg;
                    text_val   = in_data;
                    count_next = count_reg + 8'd1;
                    load_b[0]  = in_data;
                    load_n     = 2'd1;
                end else begin
                    overflow_next = 1'b1;
                    load_b[0]     = 8'h07;
                    load_n        = 2'd1;
                end
            end else if (is_bs) begin
                if (count_reg != 8'd0) begin
                    text_we    = 1'b1;
                    text_idx   = count_reg - 8'd1;
                    text_val   = 8'h00;
                    count_next = count_reg - 8'd1;
                    load_b[0]  = 8'h08;
                    load_b[1]  = 8'h20;
                    load_b[2]  = 8'h08;
                    load_n     = 2'd3;
                end
            end else if (is_cr) begin
                load_b[0]  = 8'h0D;
                load_b[1]  = 8'h0A;
                load_n     = 2'd2;
                state_next = HOLD;
            end
        end

        // An accept only happens with an empty queue, so loading never collides with a pop.
        if (ECHO_EN && (load_n != 2'd0)) begin
            echo_q_next   = load_b;
            echo_occ_next = load_n;
        end

        if (line_take) begin
            text_clr      = 1'b1;
            count_next    = 8'd0;
            overflow_next = 1'b0;
            state_next    = COLLECT;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_reg    <= COLLECT;
            count_reg    <= 8'd0;
            overflow_reg <= 1'b0;
            echo_occ_reg <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                echo_q_reg[i] <= 8'h00;
            end
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            echo_occ_reg <= echo_occ_next;
            echo_q_reg   <= echo_q_next;
        end
    end

    // One register per character slot; a slot only changes on a store, a backspace or a line take.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_LEN; gi++) begin : g_text
            localparam logic [7:0] IDX = 8'(gi);
            logic [7:0] byte_reg;

            always_ff @(posedge clk_48mhz) begin
                if (reset || text_clr) begin
                    byte_reg <= 8'h00;
                end else if (text_we && (text_idx == IDX)) begin
                    byte_reg <= text_val;
                end
            end

            assign line_text[8*gi +: 8] = byte_reg;
        end
    endgenerate

endmodule

// File: tb/tb_uart_line_rx.sv
// Bench for uart_line_rx: directed scenarios plus random lines checked against a queue-based line editor model.
module tb_uart_line_rx;

    localparam int LL    = 32;
    localparam int LIMIT = 5000;

    logic           clk_48mhz = 1'b0;
    logic           reset = 1'b1;
    logic [7:0]     in_data = 8'h00;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [7:0]     echo_data;
    logic           echo_valid;
    logic           echo_ready = 1'b1;
    logic [8*LL-1:0] line_text;
    logic [7:0]     line_length;
    logic           line_overflow;
    logic           line_valid;
    logic           line_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    bit rand_bp = 1'b0;

    // reference model state
    logic [7:0]     mline [$];
    bit             movf = 1'b0;
    logic [7:0]     exp_echo [$];
    logic [7:0]     got_echo [$];
    logic [255:0]   exp_text [$];
    logic [7:0]     exp_len [$];
    logic           exp_ovf [$];
    logic [255:0]   got_text [$];
    logic [7:0]     got_len [$];
    logic           got_ovf [$];

    uart_line_rx #(.LINE_LEN(LL), .ECHO(1)) dut (
        .clk_48mhz    (clk_48mhz),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .echo_data    (echo_data),
        .echo_valid   (echo_valid),
        .echo_ready   (echo_ready),
        .line_text    (line_text),
        .line_length  (line_length),
        .line_overflow(line_overflow),
        .line_valid   (line_valid),
        .line_ready   (line_ready)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    // Handshakes complete on the next rising edge; inputs only change just after rising edges.
    always @(negedge clk_48mhz) begin
        if (!reset && echo_valid && echo_ready) got_echo.push_back(echo_data);
        if (!reset && line_valid && line_ready) begin
            got_text.push_back(line_text);
            got_len.push_back(line_length);
            got_ovf.push_back(line_overflow);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] b);
        logic [255:0] t;
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (mline.size() < LL) begin
                mline.push_back(b);
                exp_echo.push_back(b);
            end else begin
                movf = 1'b1;
                exp_echo.push_back(8'h07);
            end
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (mline.size() > 0) begin
                void'(mline.pop_back());
                exp_echo.push_back(8'h08);
                exp_echo.push_back(8'h20);
                exp_echo.push_back(8'h08);
            end
        end else if (b == 8'h0D) begin
            exp_echo.push_back(8'h0D);
            exp_echo.push_back(8'h0A);
            t = '0;
            foreach (mline[i]) t[8*i +: 8] = mline[i];
            exp_text.push_back(t);
            exp_len.push_back(8'(mline.size()));
            exp_ovf.push_back(movf);
            mline.delete();
            movf = 1'b0;
        end
    endtask

    task automatic randomize_ready();
        if (rand_bp) begin
            echo_ready = ($urandom_range(0, 3) != 0);
            line_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic send_raw(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk_48mhz);
            if (in_ready || n >= LIMIT) break;
            @(posedge clk_48mhz); #1;
            randomize_ready();
            n++;
        end
        chk("send_timeout", 256'(n < LIMIT), 256'(1));
        @(posedge clk_48mhz); #1;
        in_valid = 1'b0;
        randomize_ready();
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(b);
        model_accept(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((got_echo.size() < exp_echo.size() || got_len.size() < exp_len.size()) && n < LIMIT) begin
            @(posedge clk_48mhz); #1;
            randomize_ready();
            n++;
        end
        repeat (3) @(posedge clk_48mhz);
        #1;
        chk("drain_timeout", 256'(n < LIMIT), 256'(1));
    endtask

    task automatic check_streams(input string tag);
        int ne, nl;
        chk({tag, "_echo_count"}, 256'(got_echo.size()), 256'(exp_echo.size()));
        ne = (got_echo.size() < exp_echo.size()) ? got_echo.size() : exp_echo.size();
        for (int i = 0; i < ne; i++)
            chk($sformatf("%s_echo[%0d]", tag, i), 256'(got_echo[i]), 256'(exp_echo[i]));
        chk({tag, "_line_count"}, 256'(got_len.size()), 256'(exp_len.size()));
        nl = (got_len.size() < exp_len.size()) ? got_len.size() : exp_len.size();
        for (int i = 0; i < nl; i++) begin
            $display("line %s[%0d] len=%0d ovf=%0d text=%0h", tag, i, got_len[i], got_ovf[i], got_text[i]);
            chk($sformatf("%s_text[%0d]", tag, i), got_text[i], exp_text[i]);
            chk($sformatf("%s_len[%0d]", tag, i), 256'(got_len[i]), 256'(exp_len[i]));
            chk($sformatf("%s_ovf[%0d]", tag, i), 256'(got_ovf[i]), 256'(exp_ovf[i]));
        end
        exp_echo.delete(); got_echo.delete();
        exp_text.delete(); exp_len.delete(); exp_ovf.delete();
        got_text.delete(); got_len.delete(); got_ovf.delete();
    endtask

    initial begin
        logic [255:0] held;
        bit           stable;
        int           n;
        logic [7:0]   b;
        int           r;

        // reset state
        repeat (3) @(posedge clk_48mhz);
        #1 reset = 1'b0;
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_echo_valid", 256'(echo_valid), 256'(0));
        chk("rst_line_valid", 256'(line_valid), 256'(0));
        chk("rst_line_length", 256'(line_length), 256'(0));
        chk("rst_line_text", line_text, 256'(0));
        chk("rst_overflow", 256'(line_overflow), 256'(0));

        // 1: plain command line, literal packing check
        send_str("get-mask");
        send(8'h0D);
        drain();
        if (got_text.size() > 0) begin
            chk("t1_literal", 256'(got_text[0][63:0]), 256'(64'h6b73616d2d746567));
            chk("t1_upper_zero", 256'(got_text[0][255:64]), 256'(0));
        end
        check_streams("t1");

        // 2: backspace editing
        send_str("ab");
        send(8'h08);
        send_str("c");
        send(8'h0D);
        drain();
        if (got_text.size() > 0) chk("t2_literal", 256'(got_text[0][15:0]), 256'(16'h6361));
        check_streams("t2");

        // 3: overflow
        repeat (40) send(8'h78);
        send(8'h0D);
        drain();
        check_streams("t3");

        // 4: echo and line backpressure
        echo_ready = 1'b0;
        send("q");
        chk("t4_in_ready_low", 256'(in_ready), 256'(0));
        chk("t4_echo_valid", 256'(echo_valid), 256'(1));
        chk("t4_echo_data", 256'(echo_data), 256'(8'h71));
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk_48mhz); #1;
            if (in_ready || !echo_valid || echo_data != 8'h71) stable = 1'b0;
        end
        chk("t4_echo_hold", 256'(stable), 256'(1));
        echo_ready = 1'b1;
        @(posedge clk_48mhz); #1;
        chk("t4_in_ready_back", 256'(in_ready), 256'(1));
        line_ready = 1'b0;
        send(8'h0D);
        n = 0;
        do begin
            @(negedge clk_48mhz);
            n++;
        end while (!line_valid && n < LIMIT);
        chk("t4_line_valid_timeout", 256'(n < LIMIT), 256'(1));
        held = line_text;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk_48mhz);
            if (!line_valid || line_text !== held || in_ready || line_length != 8'd1) stable = 1'b0;
        end
        chk("t4_hold_stable", 256'(stable), 256'(1));
        @(posedge clk_48mhz); #1;
        line_ready = 1'b1;
        @(posedge clk_48mhz); #1;
        chk("t4_line_valid_low", 256'(line_valid), 256'(0));
        chk("t4_text_cleared", line_text, 256'(0));
        chk("t4_len_cleared", 256'(line_length), 256'(0));
        drain();
        check_streams("t4");

        // 5: edits and controls at count 0, then empty line
        send(8'h08);
        send(8'h0A);
        send(8'h01);
        repeat (4) @(posedge clk_48mhz);
        #1;
        chk("t5_no_echo", 256'(got_echo.size()), 256'(0));
        chk("t5_len_zero", 256'(line_length), 256'(0));
        send(8'h0D);
        drain();
        check_streams("t5");

        // 6: reset during an echo discards the partial line
        send_str("ab");
        drain();
        check_streams("t6a");
        echo_ready = 1'b0;
        send_raw("c");
        chk("t6_echo_c", 256'(echo_data), 256'(8'h63));
        reset = 1'b1;
        @(posedge clk_48mhz); #1;
        reset = 1'b0;
        mline.delete();
        movf = 1'b0;
        chk("t6_echo_valid", 256'(echo_valid), 256'(0));
        chk("t6_len", 256'(line_length), 256'(0));
        chk("t6_line_valid", 256'(line_valid), 256'(0));
        chk("t6_in_ready", 256'(in_ready), 256'(1));
        echo_ready = 1'b1;
        send("x");
        send(8'h0D);
        drain();
        check_streams("t6b");

        // 7: random lines under random backpressure
        rand_bp = 1'b1;
        for (int ln = 0; ln < 8; ln++) begin
            n = $urandom_range(0, 45);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 99);
                if (r < 70)      b = 8'($urandom_range(32, 126));
                else if (r < 82) b = (r[0]) ? 8'h08 : 8'h7F;
                else if (r < 92) b = 8'($urandom_range(0, 31));
                else             b = 8'h7F;
                send(b);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk_48mhz); #1;
                    randomize_ready();
                end
            end
            send(8'h0D);
        end
        drain();
        rand_bp = 1'b0;
        echo_ready = 1'b1;
        line_ready = 1'b1;
        drain();
        check_streams("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
